instr_prefetch_buf0: RTL and testbench
======================================

// Module: instr_prefetch_buf0
// PURPOSE
// - Sequential instruction prefetcher sitting directly upstream of the core0 instruction RAM/boot-ROM wrapper.
// - Issues word reads (1-cycle read latency) to the RAM side and buffers the returned words in a small FIFO.
// - Presents each buffered word to the core fetch stage through a valid/ready handshake.
// - Supports branch redirect with flush.
// PARAMETERS
// - ADDR_WIDTH  16       byte-address width toward RAM; MSB set = boot ROM region
// - DATA_WIDTH  32       instruction word width
// - FIFO_DEPTH  4        buffered words (power of 2, >=2)
// - BOOT_ADDR   16'h8000 fetch address after reset (word aligned)
// PORTS
// - clk            in   1           clock; all logic on rising edge
// - rst            in   1           synchronous, active-high reset
// - fetch_en_i     in   1           1 = prefetching allowed
// - branch_i       in   1           redirect request (single-cycle pulse)
// - branch_addr_i  in   ADDR_WIDTH  redirect target; bits[1:0] ignored (treated as 0)
// - instr_valid_o  out  1           FIFO head valid
// - instr_rdata_o  out  DATA_WIDTH  FIFO head instruction word
// - instr_addr_o   out  ADDR_WIDTH  byte address of FIFO head word
// - instr_ready_i  in   1           core accepts head when valid & ready
// - ram_en_o       out  1           RAM read strobe
// - ram_addr_o     out  ADDR_WIDTH  RAM byte address; bits[1:0] always 0
// - ram_rdata_i    in   DATA_WIDTH  read data, valid exactly 1 cycle after ram_en_o
// BEHAVIOUR
// - Clock/reset: one clock; reset is synchronous and active-high.
// - Reset values (also on reset asserted mid-operation):
//   - Outputs: instr_valid_o=0, ram_en_o=0, FIFO count=0, inflight=0.
//   - fetch_addr = BOOT_ADDR; a response pending at reset is discarded.
//   - instr_rdata_o / instr_addr_o are don't-care while instr_valid_o=0.
// - State:
//   - fetch_addr: next address to issue.
//   - inflight (1b): a read was issued last cycle; inflight_addr holds its address.
//   - FIFO of {addr, data}, depth FIFO_DEPTH.
// - Issue, no branch:
//   - ram_en_o = fetch_en_i & (count + inflight - pop < FIFO_DEPTH).
//   - pop = instr_valid_o & instr_ready_i.
//   - ram_addr_o = fetch_addr.
//   - On issue: fetch_addr += 4, wrapping modulo 2^ADDR_WIDTH, so the top address wraps to 0.
// - Response: when inflight=1, push {inflight_addr, ram_rdata_i} into the FIFO that cycle. No backpressure; the issue rule guarantees space.
// - Output: the FIFO head is registered, so a push becomes visible as instr_valid_o on the next cycle.
//   - Issue-to-valid latency = 2 cycles.
//   - A continuously ready core sees 1 word per cycle.
// - Simultaneous push and pop: both take effect; count is unchanged. Push into a full FIFO cannot occur (assertion).
// - Branch (branch_i=1), highest priority:
//   - FIFO is flushed; any same-cycle pop is ignored; instr_valid_o=0 next cycle.
//   - The response of the read issued in the previous cycle is discarded (not pushed).
//   - This cycle: ram_addr_o = {branch_addr_i[ADDR_WIDTH-1:2],2'b00}; ram_en_o = fetch_en_i (FIFO is treated as empty).
//   - fetch_addr <= target + 4 if issued, else target.
//   - Branch-to-first-valid = 2 cycles when fetch_en_i=1.
// - fetch_en_i=0: no new issues. An inflight response is still pushed, and buffered words still drain.
// - Boot/RAM region: transparent; the MSB of the address passes through unchanged.
// TESTING
// - Reset, fetch_en=1, ready=1 -> ram_addr 0x8000,0x8004,0x8008...; first instr_valid 2 cycles after first ram_en, one word/cycle, instr_addr matches.
// - ready=0 with fetch_en=1 -> exactly 4 issues, FIFO holds 4 words, ram_en stays 0; ready=1 for 1 cycle -> one pop, exactly one new issue next cycle.
// - branch_i to 0x0102 while 2 words buffered and 1 inflight -> next cycle valid=0; discarded word never appears; ram_addr 0x0100 in branch cycle, first valid addr 0x0100 2 cycles later.
// - fetch_addr=0xFFFC issue -> next ram_addr 0x0000 (wrap).
// - Reset pulsed while FIFO full and inflight -> valid=0, ram_en=0 next cycle; after release, fetch resumes at 0x8000, no stale data.
// - fetch_en dropped with read inflight -> that word still delivered, no further ram_en.

Source files
------------

// File: rtl/instr_prefetch_buf0.sv
// instr_prefetch_buf0
//   Sequential instruction prefetcher in front of the core0 instruction RAM / boot-ROM wrapper.
//   Issues single-word reads (1-cycle read latency), buffers the returned words with their
//   addresses in a small FIFO and hands the FIFO head to the fetch stage over valid/ready.
//   A branch flushes the FIFO, drops the response in flight and restarts fetching at the
//   target in the same cycle.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   fetch_en_i     prefetching allowed
//   branch_i       redirect pulse; branch_addr_i is the target (bits [1:0] ignored)
//   instr_valid_o  FIFO head valid; instr_rdata_o / instr_addr_o carry the head word/address
//   instr_ready_i  core accepts the head when valid & ready
//   ram_en_o       RAM read strobe; ram_addr_o word-aligned byte address
//   ram_rdata_i    read data, valid one cycle after ram_en_o
module instr_prefetch_buf0 #(
  parameter int unsigned            ADDR_WIDTH = 16,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0]  BOOT_ADDR  = 16'h8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_ready_i,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [CntW:0]   DepthOcc = (CntW + 1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;

  logic                  pop_req, pop, push;
  logic [CntW:0]         occ;
  logic [ADDR_WIDTH-1:0] branch_target;

  logic unused_branch_lsbs;
  assign unused_branch_lsbs = ^branch_addr_i[1:0];

  assign branch_target = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};

  // Head comes straight from registers, so a push shows up as valid one cycle later.
  assign instr_valid_o = (count_q != '0);
  assign instr_rdata_o = fifo_data_q[rd_ptr_q];
  assign instr_addr_o  = fifo_addr_q[rd_ptr_q];

  assign pop_req = instr_valid_o & instr_ready_i;
  // A branch flushes the FIFO: same-cycle pop and the previous cycle's response are dropped.
  assign pop     = pop_req & ~branch_i;
  assign push    = inflight_q & ~branch_i;

  // Words already buffered plus the one returning next cycle, less the one leaving now.
  assign occ = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop_req};

  always_comb begin
    ram_addr_o = fetch_addr_q;
    ram_en_o   = fetch_en_i && (occ < DepthOcc);
    if (branch_i) begin
      ram_addr_o = branch_target;
      ram_en_o   = fetch_en_i;
    end
    if (rst) begin
      ram_en_o = 1'b0;
    end
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (ram_en_o) begin
      fetch_addr_d = ram_addr_o + ADDR_WIDTH'(4);  // wraps modulo 2^ADDR_WIDTH
    end else if (branch_i) begin
      fetch_addr_d = branch_target;
    end
  end

  always_comb begin
    count_d = count_q;
    if (branch_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{(CntW - 1){1'b0}}, push} - {{(CntW - 1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_q    <= BOOT_ADDR;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      fetch_addr_q    <= fetch_addr_d;
      inflight_q      <= ram_en_o;
      inflight_addr_q <= ram_addr_o;
      count_q         <= count_d;
      if (branch_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
      fifo_data_q[wr_ptr_q] <= ram_rdata_i;
    end
  end

  // The issue rule reserves a slot for every read, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      assert (count_q != DepthCnt);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buf0.sv
module tb_instr_prefetch_buf0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [15:0] branch_addr_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [15:0] instr_addr_o;
  logic        instr_ready_i = 1'b0;
  logic        ram_en_o;
  logic [15:0] ram_addr_o;
  logic [31:0] ram_rdata_i = '0;

  int checks = 0;
  int failures = 0;
  int issues;

  instr_prefetch_buf0 dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en_i    (fetch_en_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .instr_valid_o (instr_valid_o),
    .instr_rdata_o (instr_rdata_o),
    .instr_addr_o  (instr_addr_o),
    .instr_ready_i (instr_ready_i),
    .ram_en_o      (ram_en_o),
    .ram_addr_o    (ram_addr_o),
    .ram_rdata_i   (ram_rdata_i)
  );

  always #5 clk = ~clk;

  // RAM with 1-cycle latency; each word encodes its own address.
  always @(posedge clk) begin
    if (ram_en_o) ram_rdata_i <= {16'hC0DE, ram_addr_o};
  end

  // Apply one cycle's inputs just after the edge, then leave time for outputs to settle.
  task automatic step(input logic r, input logic fe, input logic rdy, input logic br,
                      input logic [15:0] ba);
    @(posedge clk);
    #1;
    rst = r;
    fetch_en_i = fe;
    instr_ready_i = rdy;
    branch_i = br;
    branch_addr_i = ba;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic rdy);
    step(1'b1, 1'b1, rdy, 1'b0, 16'h0);
    chk("rst_ram_en_a", {31'b0, ram_en_o}, 32'd0);
    step(1'b1, 1'b1, rdy, 1'b0, 16'h0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_ram_en_b", {31'b0, ram_en_o}, 32'd0);
  endtask

  initial begin
    // Streaming from boot address with an always-ready core.
    do_reset(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("s0_ram_en", {31'b0, ram_en_o}, 32'd1);
    chk("s0_ram_addr", {16'b0, ram_addr_o}, 32'h8000);
    chk("s0_valid", {31'b0, instr_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("s1_ram_addr", {16'b0, ram_addr_o}, 32'h8004);
    chk("s1_valid", {31'b0, instr_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("s2_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("s2_addr", {16'b0, instr_addr_o}, 32'h8000);
    chk("s2_data", instr_rdata_o, 32'hC0DE8000);
    chk("s2_ram_addr", {16'b0, ram_addr_o}, 32'h8008);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("s3_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("s3_addr", {16'b0, instr_addr_o}, 32'h8004);
    chk("s3_data", instr_rdata_o, 32'hC0DE8004);

    // Stalled core: prefetch stops once the FIFO is committed full.
    do_reset(1'b0);
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      if (ram_en_o) issues++;
    end
    chk("full_issues", issues, 32'd4);
    chk("full_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("full_head", {16'b0, instr_addr_o}, 32'h8000);
    chk("full_ram_en", {31'b0, ram_en_o}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("pop1_ram_en", {31'b0, ram_en_o}, 32'd1);
    chk("pop1_ram_addr", {16'b0, ram_addr_o}, 32'h8010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("pop2_ram_en", {31'b0, ram_en_o}, 32'd0);
    chk("pop2_head", {16'b0, instr_addr_o}, 32'h8004);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("pop3_ram_en", {31'b0, ram_en_o}, 32'd0);

    // Branch with two words buffered and one read in flight.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0102);
    chk("br_pre_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("br_ram_en", {31'b0, ram_en_o}, 32'd1);
    chk("br_ram_addr", {16'b0, ram_addr_o}, 32'h0100);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("br1_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("br1_ram_addr", {16'b0, ram_addr_o}, 32'h0104);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("br2_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("br2_addr", {16'b0, instr_addr_o}, 32'h0100);
    chk("br2_data", instr_rdata_o, 32'hC0DE0100);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("br3_addr", {16'b0, instr_addr_o}, 32'h0104);

    // Address wrap at the top of the space.
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE);
    chk("wr0_ram_addr", {16'b0, ram_addr_o}, 32'hFFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("wr1_ram_addr", {16'b0, ram_addr_o}, 32'h0000);
    chk("wr1_valid", {31'b0, instr_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("wr2_addr", {16'b0, instr_addr_o}, 32'hFFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("wr3_addr", {16'b0, instr_addr_o}, 32'h0000);
    chk("wr3_data", instr_rdata_o, 32'hC0DE0000);

    // Reset mid-operation with buffered words and a read in flight.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("mr0_ram_en", {31'b0, ram_en_o}, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("mr1_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("mr1_ram_en", {31'b0, ram_en_o}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("mr2_ram_addr", {16'b0, ram_addr_o}, 32'h8000);
    chk("mr2_valid", {31'b0, instr_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("mr3_valid", {31'b0, instr_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("mr4_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("mr4_addr", {16'b0, instr_addr_o}, 32'h8000);

    // fetch_en dropped while a read is in flight.
    do_reset(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("fe0_ram_en", {31'b0, ram_en_o}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("fe1_ram_en", {31'b0, ram_en_o}, 32'd0);
    chk("fe1_valid", {31'b0, instr_valid_o}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("fe2_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("fe2_data", instr_rdata_o, 32'hC0DE8000);
    chk("fe2_ram_en", {31'b0, ram_en_o}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("fe3_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("fe3_ram_en", {31'b0, ram_en_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
